// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped BTB with saturating direction counters at fetch,
// misprediction redirect at EX resolve, a sticky halt state and saturating statistics.
module branch_predict_unit #(
  parameter int PC_W  = 9,
  parameter int IDX_W = 4,
  parameter int CTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  F_PC,
  output logic             F_PredTaken,
  output logic [31:0]      F_PredPC,
  output logic             F_BtbHit,
  input  logic             E_Valid,
  input  logic [PC_W-1:0]  E_PC,
  input  logic [31:0]      E_Imm,
  input  logic             E_Branch,
  input  logic             E_JmpSel,
  input  logic             E_JalrSel,
  input  logic [31:0]      E_AluResult,
  input  logic [31:0]      E_PredPC,
  input  logic             flag_halt,
  output logic [31:0]      PC_Imm,
  output logic [31:0]      PC_Four,
  output logic [31:0]      BrPC,
  output logic             PcSel,
  output logic             Halted,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_ONE = 1;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_ONE << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_ONE;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, HALT} state_t;

  state_t       state_q;
  logic         halted_q;
  logic [31:0]  halt_pc_q;

  logic             btb_valid  [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [31:0]      btb_target [ENTRIES];
  logic             btb_jmp    [ENTRIES];
  logic [CTR_W-1:0] btb_ctr    [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [31:0]      f_pc_ext;
  logic             f_hit;
  logic             f_pred_raw;

  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic [31:0]      e_pc_ext;
  logic             e_hit;
  logic             taken;
  logic [31:0]      target_pc;
  logic [31:0]      next_seq_pc;
  logic [31:0]      correct_pc;
  logic             mispredict;
  logic             upd_en;

  // Fetch side reads registered BTB state only, so an update landing this cycle is seen next cycle.
  assign f_idx      = F_PC[IDX_W+1:2];
  assign f_tag      = F_PC[PC_W-1:IDX_W+2];
  assign f_pc_ext   = 32'(F_PC);
  assign f_hit      = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign f_pred_raw = f_hit && (btb_jmp[f_idx] || btb_ctr[f_idx][CTR_W-1]);

  assign F_BtbHit    = f_hit;
  assign F_PredTaken = !halted_q && f_pred_raw;
  assign F_PredPC    = halted_q   ? halt_pc_q :
                       f_pred_raw ? btb_target[f_idx] : f_pc_ext + 32'd4;

  assign e_idx       = E_PC[IDX_W+1:2];
  assign e_tag       = E_PC[PC_W-1:IDX_W+2];
  assign e_pc_ext    = 32'(E_PC);
  assign e_hit       = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
  assign taken       = (E_Branch && E_AluResult[0]) || E_JmpSel;
  assign target_pc   = E_JalrSel ? E_AluResult : e_pc_ext + E_Imm;
  assign next_seq_pc = e_pc_ext + 32'd4;
  assign correct_pc  = taken ? target_pc : next_seq_pc;
  assign mispredict  = E_Valid && !halted_q && (E_PredPC != correct_pc);
  assign upd_en      = E_Valid && !halted_q && (E_Branch || E_JmpSel) && !flag_halt;

  assign PC_Imm       = target_pc;
  assign PC_Four      = next_seq_pc;
  assign PcSel        = halted_q || mispredict;
  assign BrPC         = halted_q ? halt_pc_q : (mispredict ? correct_pc : 32'd0);
  assign Halted       = halted_q;
  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;

  // Hits retrain target and counter; a miss only allocates when the branch was actually taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= 32'd0;
        btb_jmp[i]    <= 1'b0;
        btb_ctr[i]    <= CTR_WNT;
      end
    end else if (upd_en) begin
      if (e_hit) begin
        btb_target[e_idx] <= target_pc;
        btb_jmp[e_idx]    <= E_JmpSel;
        if (taken) begin
          if (btb_ctr[e_idx] != CTR_MAX) btb_ctr[e_idx] <= btb_ctr[e_idx] + CTR_ONE;
        end else if (btb_ctr[e_idx] != '0) begin
          btb_ctr[e_idx] <= btb_ctr[e_idx] - CTR_ONE;
        end
      end else if (taken) begin
        btb_valid[e_idx]  <= 1'b1;
        btb_tag[e_idx]    <= e_tag;
        btb_target[e_idx] <= target_pc;
        btb_jmp[e_idx]    <= E_JmpSel;
        btb_ctr[e_idx]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (upd_en) begin
      if (branch_cnt_q != CNT_MAX) branch_cnt_q <= branch_cnt_q + CNT_ONE;
      if (mispredict && (mispred_cnt_q != CNT_MAX)) mispred_cnt_q <= mispred_cnt_q + CNT_ONE;
    end
  end

  // HALT is sticky; only reset brings the unit back to RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      halted_q  <= 1'b0;
      halt_pc_q <= 32'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (E_Valid && flag_halt) begin
            state_q   <= HALT;
            halted_q  <= 1'b1;
            halt_pc_q <= e_pc_ext;
          end
        end
        HALT: begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
